// File: rtl/display_pkg.sv
// Shared helpers for the seven-segment scan driver: width derivation and
// polarity-aware "all digits off" select vector.
package display_pkg;

    // Upper bound on digit count supported by sel_inactive().
    localparam int MAX_DIGITS = 32;

    // Scan index width; a single bit even for tiny digit counts.
    function automatic int scan_width(input int num_digits);
        return (num_digits < 2) ? 1 : $clog2(num_digits);
    endfunction

    // Prescaler width, wide enough to hold div-1.
    function automatic int pre_width(input int div);
        return $clog2(div);
    endfunction

    // All-off select vector: all ones for common anode, all zeros otherwise.
    // Callers truncate to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] sel_inactive(input bit active_low);
        return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/display_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while enabled, holds while disabled, and
// flags the last cycle of a slot. The next-count is exported so the top can
// register outputs that line up with the counter value they describe.
module display_prescaler
    import display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int PRE_W = pre_width(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [PRE_W-1:0] pre,
    output logic [PRE_W-1:0] pre_nxt,
    output logic             wrap
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    // Next count: hold when disabled, wrap to zero after DIV-1.
    always_comb begin
        wrap    = en && (pre == PRE_MAX);
        pre_nxt = pre;
        if (wrap)
            pre_nxt = '0;
        else if (en)
            pre_nxt = pre + PRE_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else
            pre <= pre_nxt;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment digit driver. Digit values are captured once
// per frame (slot 0, prescaler 0) so a frame never mixes old and new values;
// the select is blanked for the first BLANK_CYC cycles of each slot.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_W         = 4,
    parameter int DIV            = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    localparam int SCAN_W        = scan_width(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        digit_en,
    output logic [SCAN_W-1:0]            scan,
    output logic [DATA_W-1:0]            data_out,
    output logic [NUM_DIGITS-1:0]        sel,
    output logic                         frame_start
);

    localparam int                  PRE_W    = pre_width(DIV);
    localparam logic [PRE_W-1:0]    BLANK    = PRE_W'(BLANK_CYC);
    localparam logic [SCAN_W-1:0]   SCAN_MAX = SCAN_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = NUM_DIGITS'(sel_inactive(SEL_ACTIVE_LOW));

    logic [PRE_W-1:0]             pre;
    logic [PRE_W-1:0]             pre_nxt;
    logic                         wrap;
    logic [SCAN_W-1:0]            scan_nxt;
    logic [NUM_DIGITS*DATA_W-1:0] snap;
    logic [NUM_DIGITS-1:0]        sel_nxt;
    logic                         frame_go;

    display_prescaler #(
        .DIV   (DIV),
        .PRE_W (PRE_W)
    ) u_pre (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pre     (pre),
        .pre_nxt (pre_nxt),
        .wrap    (wrap)
    );

    // Slot index advances on prescaler wrap; explicit wrap keeps a
    // non-power-of-2 digit count inside 0..NUM_DIGITS-1.
    always_comb begin
        scan_nxt = scan;
        if (wrap)
            scan_nxt = (scan == SCAN_MAX) ? '0 : scan + SCAN_W'(1);
    end

    assign frame_go = en && (pre == '0) && (scan == '0);

    // Select decode from the post-edge slot position, so the registered sel
    // is active exactly while the counter sits at BLANK_CYC..DIV-1.
    always_comb begin
        sel_nxt = SEL_OFF;
        if (en && (pre_nxt >= BLANK) && digit_en[scan_nxt])
            sel_nxt[scan_nxt] = ~SEL_ACTIVE_LOW;
    end

    // Scan index, frame snapshot, digit mux and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan        <= '0;
            snap        <= '0;
            data_out    <= '0;
            sel         <= SEL_OFF;
            frame_start <= 1'b0;
        end else begin
            scan        <= scan_nxt;
            frame_start <= frame_go;
            sel         <= sel_nxt;
            if (frame_go)
                snap <= digits_in;
            // Reads the pre-load snapshot; the one-cycle lag is covered by blanking.
            if (en)
                data_out <= snap[int'(scan) * DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux. A time-based reference model (count
// of enabled cycles since reset -> slot position) predicts every cycle's
// outputs; a monitor pops and compares one prediction after each clock edge.
module tb_display_scan_mux;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [ND*DW-1:0]  digits_in;
    logic [ND-1:0]     digit_en;
    logic [1:0]        scan;
    logic [DW-1:0]     data_out;
    logic [ND-1:0]     sel;
    logic              frame_start;

    typedef struct {
        logic [3:0] sel;
        logic [1:0] scan;
        logic [3:0] data;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         t;
    logic [3:0] snap_m[ND];
    logic [3:0] data_m;

    logic [15:0] cur_d;
    logic [3:0]  cur_m;

    display_scan_mux #(
        .NUM_DIGITS     (ND),
        .DATA_W         (DW),
        .DIV            (DIV),
        .BLANK_CYC      (BLANK),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits_in   (digits_in),
        .digit_en    (digit_en),
        .scan        (scan),
        .data_out    (data_out),
        .sel         (sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t x);
        checks++;
        if (sel !== x.sel || scan !== x.scan || data_out !== x.data || frame_start !== x.fs) begin
            errors++;
            $display("FAIL %s @%0t: got sel=%b scan=%0d data=%h fs=%b, want sel=%b scan=%0d data=%h fs=%b",
                     name, $time, sel, scan, data_out, frame_start, x.sel, x.scan, x.data, x.fs);
        end
    endtask

    task automatic model_reset();
        t = 0;
        data_m = '0;
        for (int i = 0; i < ND; i++) snap_m[i] = '0;
    endtask

    // One clock of stimulus; prediction for the following edge is queued.
    task automatic drive(input logic e, input logic [15:0] d, input logic [3:0] m);
        exp_t x;
        int   s, s2, p2;
        @(negedge clk);
        rst_n = 1'b1;
        en = e;
        digits_in = d;
        digit_en = m;
        x.sel = 4'b1111;
        x.fs  = 1'b0;
        if (e) begin
            s = (t / DIV) % ND;
            data_m = snap_m[s];
            if (t % (DIV * ND) == 0) begin
                x.fs = 1'b1;
                for (int i = 0; i < ND; i++) snap_m[i] = d[i*4 +: 4];
            end
            t++;
            p2 = t % DIV;
            s2 = (t / DIV) % ND;
            if (p2 >= BLANK && m[s2]) x.sel[s2] = 1'b0;
        end
        x.data = data_m;
        x.scan = 2'((t / DIV) % ND);
        q.push_back(x);
    endtask

    // Asynchronous reset away from any edge; outputs must clear immediately.
    task automatic do_reset(input string name);
        exp_t x;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        model_reset();
        #1;
        x.sel = 4'b1111; x.scan = 2'd0; x.data = 4'h0; x.fs = 1'b0;
        check(name, x);
    endtask

    function automatic int pre_m();
        return t % DIV;
    endfunction

    function automatic int scan_m();
        return (t / DIV) % ND;
    endfunction

    // Monitor: compare one prediction per clock, clear of the active edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("cycle", x);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        digits_in = '0;
        digit_en = '0;
        model_reset();

        // Reset before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        begin
            exp_t x;
            x.sel = 4'b1111; x.scan = 2'd0; x.data = 4'h0; x.fs = 1'b0;
            check("reset_initial", x);
        end

        // Normal scan
        cur_d = 16'h4321;
        cur_m = 4'hF;
        repeat (40) drive(1'b1, cur_d, cur_m);

        // Snapshot isolation: change digits mid-frame
        while (scan_m() != 1) drive(1'b1, cur_d, cur_m);
        cur_d = 16'h8765;
        repeat (64) drive(1'b1, cur_d, cur_m);

        // Masked digits
        cur_m = 4'b1010;
        repeat (40) drive(1'b1, cur_d, cur_m);
        cur_m = 4'hF;

        // Pause at slot 2, prescaler 4
        while (!(scan_m() == 2 && pre_m() == 4)) drive(1'b1, cur_d, cur_m);
        repeat (5) drive(1'b0, cur_d, cur_m);
        repeat (20) drive(1'b1, cur_d, cur_m);

        // Async reset mid-slot (slot 3, prescaler 5), then restart
        while (!(scan_m() == 3 && pre_m() == 5)) drive(1'b1, cur_d, cur_m);
        do_reset("reset_midslot");
        cur_d = 16'hA9CB;
        repeat (40) drive(1'b1, cur_d, cur_m);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) cur_d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) cur_m = 4'($urandom);
            if ($urandom_range(0, 299) == 0)
                do_reset("reset_random");
            else
                drive($urandom_range(0, 7) != 0, cur_d, cur_m);
        end

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
